// File: rtl/ldd_seq_ctrl_pkg.sv
// Shared types for the LDD enable sequencer: state encoding and the
// state-to-enable decode used to register the driver pins.
package ldd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OSC_ON   = 3'd1,
    ST_DIS_ON   = 3'd2,
    ST_WAIT_WIN = 3'd3,
    ST_EMIT     = 3'd4,
    ST_OUT_OFF  = 3'd5,
    ST_DIS_OFF  = 3'd6,
    ST_FAULT    = 3'd7
  } ldd_state_e;

  typedef struct packed {
    logic oscea;
    logic disea;
    logic outea;
    logic rdisn;
  } ldd_en_t;

  // The discharge line is released exactly while the oscillator is enabled.
  function automatic ldd_en_t ldd_decode(input ldd_state_e s);
    ldd_en_t en;
    en.oscea = (s != ST_IDLE) && (s != ST_FAULT);
    en.disea = (s == ST_DIS_ON) || (s == ST_WAIT_WIN) || (s == ST_EMIT) || (s == ST_OUT_OFF);
    en.outea = (s == ST_EMIT);
    en.rdisn = en.oscea;
    return en;
  endfunction

endpackage

// File: rtl/ldd_seq_ctrl_if.sv
// Command/status bundle between the PS GPIO bank (master) and the LDD
// sequencer (slave), including the gate-controller window status.
interface ldd_seq_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int TOP_W = 3
);

  logic             cmd_open;
  logic             cmd_close;
  logic [CNT_W-1:0] cmd_plus;
  logic             fault_in;
  logic [TOP_W-1:0] wdis;

  logic             ldd_oscea;
  logic             ldd_disea;
  logic             ldd_outea;
  logic             ldd_rdisn;
  logic             busy;
  logic             done;
  logic             err_to;
  logic             fault;
  logic [2:0]       state;

  modport master (
    output cmd_open, cmd_close, cmd_plus, fault_in, wdis,
    input  ldd_oscea, ldd_disea, ldd_outea, ldd_rdisn,
    input  busy, done, err_to, fault, state
  );

  modport slave (
    input  cmd_open, cmd_close, cmd_plus, fault_in, wdis,
    output ldd_oscea, ldd_disea, ldd_outea, ldd_rdisn,
    output busy, done, err_to, fault, state
  );

endinterface

// File: rtl/ldd_dwell_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module ldd_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ldd_seq_ctrl.sv
// Timed, interlocked power-up/power-down sequencer for the LDD enables,
// gating emission on the window status and limiting it to a pulse length.
module ldd_seq_ctrl
  import ldd_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int TOP_W      = 3,
  parameter int SETTLE_CYC = 125,
  parameter int WIN_TO     = 12500
) (
  input logic           clk125,
  input logic           rst,
  ldd_seq_ctrl_if.slave bus
);

  localparam int DW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = $clog2(WIN_TO + 1);
  localparam logic [DW-1:0] SETTLE_INIT = DW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(WIN_TO - 1);

  ldd_state_e       state, state_next;
  ldd_en_t          en_q;
  logic [CNT_W-1:0] plus_lat;
  logic [CNT_W-1:0] pulse_cnt;
  logic [TW-1:0]    to_cnt;
  logic             dwell_zero;
  logic             opened;
  logic             pulse_end;
  logic             accept_open;
  logic             win_timeout;
  logic             done_q;
  logic             err_q;

  assign opened    = |bus.wdis;
  assign pulse_end = (plus_lat != '0) && (pulse_cnt == CNT_W'(1));

  // Every state entry restarts the settle dwell.
  ldd_dwell_cnt #(.W(DW)) u_dwell (
    .clk      (clk125),
    .rst      (rst),
    .load     (state_next != state),
    .load_val (SETTLE_INIT),
    .zero     (dwell_zero)
  );

  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fault overrides everything; close beats open and window events.
  always_comb begin
    state_next  = state;
    accept_open = 1'b0;
    win_timeout = 1'b0;
    if (bus.fault_in) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_open && !bus.cmd_close) begin
            state_next  = ST_OSC_ON;
            accept_open = 1'b1;
          end
        end
        ST_OSC_ON: begin
          if (bus.cmd_close)   state_next = ST_DIS_OFF;
          else if (dwell_zero) state_next = ST_DIS_ON;
        end
        ST_DIS_ON: begin
          if (bus.cmd_close)   state_next = ST_OUT_OFF;
          else if (dwell_zero) state_next = ST_WAIT_WIN;
        end
        ST_WAIT_WIN: begin
          if (bus.cmd_close) begin
            state_next = ST_OUT_OFF;
          end else if (opened) begin
            state_next = ST_EMIT;
          end else if (to_cnt == TO_LAST) begin
            state_next  = ST_OUT_OFF;
            win_timeout = 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.cmd_close || !opened || pulse_end) state_next = ST_OUT_OFF;
        end
        ST_OUT_OFF: begin
          if (dwell_zero) state_next = ST_DIS_OFF;
        end
        ST_DIS_OFF: begin
          if (dwell_zero) state_next = ST_IDLE;
        end
        ST_FAULT: begin
          if (bus.cmd_close) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Pins and flags are registered from the next state so they move with it.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      en_q   <= ldd_decode(state_next);
      done_q <= (state == ST_DIS_OFF) && (state_next == ST_IDLE);
      if (accept_open)      err_q <= 1'b0;
      else if (win_timeout) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      plus_lat  <= '0;
      pulse_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      if (accept_open) plus_lat <= bus.cmd_plus;
      if ((state == ST_WAIT_WIN) && (state_next == ST_EMIT)) begin
        pulse_cnt <= plus_lat;
      end else if ((state == ST_EMIT) && (pulse_cnt != '0)) begin
        pulse_cnt <= pulse_cnt - CNT_W'(1);
      end
      if ((state == ST_WAIT_WIN) && (state_next == ST_WAIT_WIN)) to_cnt <= to_cnt + TW'(1);
      else                                                      to_cnt <= '0;
    end
  end

  assign bus.ldd_oscea = en_q.oscea;
  assign bus.ldd_disea = en_q.disea;
  assign bus.ldd_outea = en_q.outea;
  assign bus.ldd_rdisn = en_q.rdisn;
  assign bus.busy      = (state != ST_IDLE) && (state != ST_FAULT);
  assign bus.fault     = (state == ST_FAULT);
  assign bus.done      = done_q;
  assign bus.err_to    = err_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_ldd_seq_ctrl.sv
// Bench for ldd_seq_ctrl: directed corner cases plus randomized sequences
// checked against an event-timeline model of the enable waveforms.
module tb_ldd_seq_ctrl;

  localparam int S     = 4;
  localparam int WTO   = 16;
  localparam int NEVER = 100000;

  logic clk125;
  logic rst;
  int   n_tests;
  int   n_fail;

  ldd_seq_ctrl_if #(.CNT_W(32), .TOP_W(3)) bus ();

  ldd_seq_ctrl #(
    .CNT_W      (32),
    .TOP_W      (3),
    .SETTLE_CYC (S),
    .WIN_TO     (WTO)
  ) dut (
    .clk125 (clk125),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk125 = 1'b0;
  always #5 clk125 = ~clk125;

  // {oscea, disea, outea, rdisn, busy, done, err_to, fault}
  function automatic logic [7:0] obsVec();
    return {bus.ldd_oscea, bus.ldd_disea, bus.ldd_outea, bus.ldd_rdisn,
            bus.busy, bus.done, bus.err_to, bus.fault};
  endfunction

  function automatic bit isOpen(input int e, input int wo, input int wl);
    return (e >= wo) && (e < wo + wl);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, take the edge, and settle just after it.
  task automatic applyStimulus(input bit open, input bit close, input logic [2:0] wd,
                               input bit flt, input logic [31:0] plus);
    bus.cmd_open  = open;
    bus.cmd_close = close;
    bus.wdis      = wd;
    bus.fault_in  = flt;
    bus.cmd_plus  = plus;
    @(posedge clk125);
    #1;
  endtask

  // Edge 0 accepts the open; e is the edge index the outputs are sampled after.
  task automatic runScenario(input string name, input int n, input int c,
                             input int wo, input int wl, input int oo);
    int w, x, disoff, idle_e;
    bit timeout, emitted;
    logic [2:0] wd;
    logic [7:0] exp_vec;
    bit osc, dis, outp, dn, er;
    w = -1; x = -1; timeout = 1'b0; emitted = 1'b0;
    if (c <= S) begin
      disoff = c;
      idle_e = c + S;
    end else begin
      if (c <= 2 * S) begin
        x = c;
      end else begin
        for (int e = 2 * S + 1; e <= 2 * S + WTO; e++) begin
          if (e == c) begin x = e; break; end
          if (isOpen(e, wo, wl)) begin w = e; break; end
        end
        if (x < 0 && w < 0) begin
          x = 2 * S + WTO;
          timeout = 1'b1;
        end
        if (w >= 0) begin
          emitted = 1'b1;
          for (int e = w + 1; x < 0; e++) begin
            if (e == c || !isOpen(e, wo, wl) || (n != 0 && e == w + n)) x = e;
          end
        end
      end
      disoff = x + S;
      idle_e = x + 2 * S;
    end
    for (int e = 0; e <= idle_e + 2; e++) begin
      wd = isOpen(e, wo, wl) ? 3'($urandom_range(1, 7)) : 3'b000;
      applyStimulus((e == 0) || (e == oo), e == c, wd, 1'b0, 32'(n));
      osc     = (e < idle_e);
      dis     = (e >= S) && (e < disoff);
      outp    = emitted && (e >= w) && (e < x);
      dn      = (e == idle_e);
      er      = timeout && (e >= x);
      exp_vec = {osc, dis, outp, osc, osc, dn, er, 1'b0};
      checkOutput($sformatf("%s e%0d", name, e), 32'(obsVec()), 32'(exp_vec));
    end
  endtask

  task automatic runRandom(input int idx);
    int n, c, wo, wl, oo;
    n  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
    c  = ($urandom_range(0, 9) < 3) ? NEVER : int'($urandom_range(1, 60));
    wo = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 40));
    wl = int'($urandom_range(1, 30));
    oo = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 20));
    $display("[TB] rnd%0d plus=%0d close=%0d wopen=%0d wlen=%0d extra_open=%0d", idx, n, c, wo, wl, oo);
    runScenario($sformatf("rnd%0d", idx), n, c, wo, wl, oo);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.cmd_open = 1'b0; bus.cmd_close = 1'b0; bus.cmd_plus = '0;
    bus.fault_in = 1'b0; bus.wdis = '0;
    repeat (3) @(posedge clk125);
    #1;
    checkOutput("reset_vec", 32'(obsVec()), 32'h00);
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    rst = 1'b0;

    // open and close together in IDLE must not start
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0, 32'd10);
    checkOutput("race_vec", 32'(obsVec()), 32'h00);
    checkOutput("race_state", 32'(bus.state), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 32'd10);
    checkOutput("race_vec2", 32'(obsVec()), 32'h00);

    runScenario("nominal", 10, NEVER, 0, 200, -1);

    // fault in EMIT, held while close arrives, then released
    for (int e = 0; e < 12; e++) applyStimulus(e == 0, 1'b0, 3'b010, 1'b0, 32'd0);
    checkOutput("pre_fault_vec", 32'(obsVec()), 32'hF8);
    checkOutput("pre_fault_state", 32'(bus.state), 32'd4);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b1, 32'd0);
    checkOutput("fault_vec", 32'(obsVec()), 32'h01);
    checkOutput("fault_state", 32'(bus.state), 32'd7);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0, 32'd0);
    checkOutput("fault_hold", 32'(obsVec()), 32'h01);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b1, 32'd0);
    checkOutput("fault_close_hi", 32'(obsVec()), 32'h01);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0, 32'd0);
    checkOutput("fault_close_lo", 32'(obsVec()), 32'h00);
    checkOutput("fault_exit_state", 32'(bus.state), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 32'd0);
    checkOutput("fault_no_done", 32'(obsVec()), 32'h00);

    // asynchronous reset while in DIS_ON
    for (int e = 0; e < S + 2; e++) applyStimulus(e == 0, 1'b0, 3'b000, 1'b0, 32'd5);
    checkOutput("pre_rst_vec", 32'(obsVec()), 32'hD8);
    checkOutput("pre_rst_state", 32'(bus.state), 32'd2);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_vec", 32'(obsVec()), 32'h00);
    checkOutput("async_rst_state", 32'(bus.state), 32'd0);
    @(posedge clk125);
    #1 rst = 1'b0;

    runScenario("timeout", 5, NEVER, NEVER, 1, -1);
    runScenario("continuous", 0, 20, 0, 200, -1);
    runScenario("open_in_emit", 8, NEVER, 0, 200, 12);
    runScenario("window_fall", 20, NEVER, 0, 14, -1);

    for (int i = 0; i < 30; i++) runRandom(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldd_seq_ctrl.md
# ldd_seq_ctrl

Sequencer for the laser-diode-driver (LDD) enable lines. It replaces direct software toggling of OSCEA/DISEA/OUTEA/RDIS with a timed, interlocked power-up and power-down sequence. Emission is gated on the gate controller's window status and limited to a programmed pulse length. It sits between the PS command GPIO bank and the LDD pins, on the clk125 domain.

## Interface
- `CNT_W`, 32, width of the pulse-length counter and the `cmd_plus` port
- `TOP_W`, 3, width of the gate-controller window status bus
- `SETTLE_CYC`, 125, dwell in cycles between successive enable steps (1 µs at 125 MHz); must be ≥ 1
- `WIN_TO`, 12500, cycles to wait for the window to open before aborting (100 µs)

Ports:
- `clk125`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `cmd_open`  in  1  single-cycle start request
- `cmd_close`  in  1  single-cycle stop request; also clears a latched fault
- `cmd_plus`  in  CNT_W  emission length in cycles, sampled on an accepted `cmd_open`; 0 means emit until `cmd_close`
- `fault_in`  in  1  level, external interlock/discharge request
- `wdis`  in  TOP_W  window status from the gate controller; opened = OR-reduce(`wdis`)
- `ldd_oscea`, `ldd_disea`, `ldd_outea`  out  1 each  LDD enables, registered
- `ldd_rdisn`  out  1  active-low discharge, registered
- `busy`  out  1  high in any state other than IDLE and FAULT
- `done`  out  1  one-cycle pulse on return to IDLE
- `err_to`  out  1  sticky window-timeout flag, cleared by the next accepted `cmd_open`
- `fault`  out  1  high in FAULT
- `state`  out  3  current state encoding, for status readback

## Operation
- States: IDLE(0), OSC_ON(1), DIS_ON(2), WAIT_WIN(3), EMIT(4), OUT_OFF(5), DIS_OFF(6), FAULT(7).
- Outputs are a registered function of the next state:
  - oscea = 1 in states 1–6
  - disea = 1 in states 2–5
  - outea = 1 only in EMIT
  - rdisn = 0 in IDLE and FAULT, 1 otherwise
- IDLE: `cmd_open` → OSC_ON. `cmd_plus` is latched and `err_to` is cleared.
- OSC_ON: after SETTLE_CYC cycles → DIS_ON.
- DIS_ON: after SETTLE_CYC cycles → WAIT_WIN.
- WAIT_WIN:
  - opened → EMIT, and the pulse counter loads the latched `cmd_plus`.
  - WIN_TO cycles elapse without opened → OUT_OFF, and `err_to` is set.
- EMIT: → OUT_OFF when any of the following occurs:
  - the counter reaches 0 (only when latched plus ≠ 0)
  - `cmd_close`
  - opened falls
- OUT_OFF: after SETTLE_CYC cycles → DIS_OFF.
- DIS_OFF: after SETTLE_CYC cycles → IDLE, with `done` pulsed.
- `cmd_close` in OSC_ON → DIS_OFF.
- `cmd_close` in DIS_ON or WAIT_WIN → OUT_OFF.
- `cmd_close` in OUT_OFF or DIS_OFF is ignored.
- `cmd_open` outside IDLE is ignored. If `cmd_open` and `cmd_close` arrive together in IDLE, close wins and the sequence does not start.
- `fault_in` high in any state → FAULT on the next edge, with all enables dropped at once. FAULT has priority over every other event.
- FAULT → IDLE on `cmd_close` while `fault_in` is low; `done` is not pulsed.

## Timing
- Reset: state=IDLE, all enables 0, `ldd_rdisn`=0, `busy`/`done`/`err_to`/`fault`=0, counters 0.
- `cmd_open` accepted at edge t:
  - `ldd_oscea`=1 from t+1
  - `ldd_disea`=1 from t+1+SETTLE_CYC
  - WAIT_WIN entered at t+1+2·SETTLE_CYC
- Opened first sampled high at edge w: `ldd_outea`=1 from w+1 for exactly N cycles when latched plus = N > 0.
- Dwell counter loads SETTLE_CYC−1 on state entry and advances when it reaches 0.
- Pulse counter: CNT_W bits, decrements while in EMIT, no wrap.
- Window timeout counter: ceil(log2(WIN_TO+1)) bits, runs only in WAIT_WIN.
- `fault_in` sampled at edge f → all enables 0 and `ldd_rdisn`=0 from f+1.
- Asynchronous reset mid-sequence forces the reset values immediately; no ramp-down is performed.

## Structure
- `ldd_pkg`: state enum and its encodings, the output-decode function from state to {oscea, disea, outea, rdisn}.
- One sub-module, `ldd_dwell_cnt`: a loadable down-counter with a zero flag. Instantiate it once for the settle dwell; the pulse counter and timeout counter stay inline.

## Test plan
All scenarios use SETTLE_CYC=4 and WIN_TO=16.
- Nominal: `cmd_plus`=10, `cmd_open`, `wdis`=3'b010 held → oscea rises at +1, disea at +5, outea high exactly 10 cycles, disea falls 4 cycles later, oscea 4 cycles after that, `done` pulses once.
- Timeout: `cmd_open` with `wdis`=0 → after 16 cycles in WAIT_WIN, ramp-down occurs with no outea pulse, and `err_to`=1 until the next `cmd_open`.
- Continuous emission: `cmd_plus`=0 → outea stays high until `cmd_close`, falls 1 cycle after it, then the normal ramp-down follows.
- Fault in EMIT: `fault_in` pulsed mid-pulse → all enables 0 and rdisn=0 next cycle. `cmd_close` with fault high keeps FAULT; with fault low it returns to IDLE with no `done`.
- Races: `cmd_open` and `cmd_close` in the same IDLE cycle → stays IDLE. `cmd_open` during EMIT → ignored. Opened falling during EMIT → outea drops next cycle.
- Reset asserted during DIS_ON → all outputs return to reset values asynchronously.
